// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared opcodes and FSM state encoding
// for the round-robin ALU scheduler.
package alu_sched_pkg;

    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_SUB     = 3'd1;
    localparam logic [2:0] OP_MUL     = 3'd2;
    localparam logic [2:0] OP_XOR     = 3'd3;
    localparam logic [2:0] OP_RSV_MIN = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_reserved(input logic [2:0] op);
        return op >= OP_RSV_MIN;
    endfunction

endpackage

// File: rtl/alu_sched_if.sv
// alu_sched_if: request/response handshake bundle between
// the requesting units and the ALU scheduler.
interface alu_sched_if #(
    parameter int N   = 4,
    parameter int W   = 16,
    parameter int IDW = $clog2(N)
);

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [3*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [IDW-1:0] rsp_id;
    logic           rsp_err;

    modport master (
        output req_valid,
        output req_op,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_id,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_id,
        output rsp_err
    );

endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// alu_sched_rr_arbiter: combinational round-robin pick of the
// first requester at or above ptr, wrapping past N-1.
module alu_sched_rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic [IDW-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 0; k < N; k++) begin
            j = IDW'((int'(ptr) + k) % N);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one combinational ALU between N requesters,
// one op at a time, with a tagged registered response.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 16,
    localparam int IDW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_sched_if.slave   bus,
    output logic [W-1:0] D1,
    output logic [W-1:0] D2,
    output logic [2:0]   MS,
    input  logic [W-1:0] ALU_out,
    output logic         busy
);

    state_t         state_q;
    state_t         state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] id_q;
    logic [W-1:0]   data_q;
    logic           err_q;

    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_any;
    logic           accept;
    logic [2:0]     sel_op;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [IDW-1:0] ptr_next;

    alu_sched_rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_arbiter (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // Operand mux from the winning requester's slices.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_op = bus.req_op[3*i +: 3];
                sel_a  = bus.req_a[W*i +: W];
                sel_b  = bus.req_b[W*i +: W];
            end
        end
    end

    assign ptr_next = (gnt_idx == IDW'(N - 1)) ? '0
                                               : gnt_idx + IDW'(1);

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.req_ready = '0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = gnt;
                if (gnt_any) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            D1      <= '0;
            D2      <= '0;
            MS      <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q <= ptr_next;
                id_q  <= gnt_idx;
                MS    <= sel_op;
                D1    <= sel_a;
                D2    <= sel_b;
            end
            // ALU settles from the operand registers during EXEC.
            if (state_q == EXEC) begin
                data_q <= ALU_out;
                err_q  <= op_reserved(MS);
            end
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler sharing the single 16-bit combinational ALU between N requesters. Each requester presents an opcode and two operands with a valid/ready handshake. The block grants one request at a time and drives the ALU operand/select inputs from registers. It captures the ALU result and returns it on a single response channel tagged with the requester index. It sits between the requesting units and the ALU instance in the parent datapath.

## Interface
- N, 4, number of requesters (2..8)
- W, 16, operand/result width; matches ALU width
- IDW, $clog2(N), requester index width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N  per-requester request valid
- req_ready  out  N  per-requester accept; at most one bit high
- req_op  in  3N  per-requester opcode, slice i = [3i+2:3i]
- req_a  in  W·N  per-requester first operand
- req_b  in  W·N  per-requester second operand
- D1  out  W  ALU operand 1 (registered)
- D2  out  W  ALU operand 2 (registered)
- MS  out  3  ALU select (registered)
- ALU_out  in  W  ALU result (combinational from D1/D2/MS)
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accepts result
- rsp_data  out  W  captured ALU result
- rsp_id  out  IDW  index of requester that issued the op
- rsp_err  out  1  opcode was reserved (4..7)
- busy  out  1  high in any state other than IDLE

## Operation
- Opcodes: 0 add, 1 sub, 2 mul (low W bits), 3 xor, 4..7 reserved. Results are modulo 2^W with no carry or overflow output.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner g is the first i with req_valid[i]=1, searching from ptr upward with wrap.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0.
  - On req_valid[g]&req_ready[g]: latch req_op/req_a/req_b slice g into MS/D1/D2, latch g into id register, set ptr←(g+1) mod N, go to EXEC.
  - With no valid request, stay in IDLE; all req_ready bits are 0.
- EXEC (exactly 1 cycle):
  - Capture ALU_out→rsp_data, MS≥4→rsp_err.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable.
  - On rsp_ready: go to IDLE.
- req_ready is 0 for all requesters in EXEC and RESP. A requester may drop req_valid before acceptance without effect.
- D1/D2/MS hold their last values after the op completes; they change only on acceptance.
- Reserved opcodes are passed to the ALU unchanged. The result is whatever the ALU produces (0), and rsp_err=1.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, ptr=0, D1=D2=0, MS=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, req_ready=0, busy=0.
- Latency: accept in cycle T → EXEC in T+1 → rsp_valid=1 from T+2.
- Minimum issue interval is 3 cycles (accept, EXEC, RESP with rsp_ready=1).
- RESP with rsp_ready=1 returns to IDLE. A new request can be accepted in the next cycle, not in the same cycle.
- Simultaneous requests are resolved by round-robin. With all N valid continuously, grant order from reset is 0,1,…,N-1,0.
- A lone requester is granted repeatedly regardless of ptr.
- rsp_ready held low: the block stalls in RESP indefinitely and holds all response outputs stable.
- Reset asserted mid-operation (EXEC or RESP): the in-flight op is dropped and no response is issued. All outputs return to reset values asynchronously.

## Structure
- Shared package holds:
  - opcode localparams OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_XOR=3
  - OP_RSV_MIN=4
  - state enum {IDLE, EXEC, RESP}
- One sub-module: rr_arbiter (inputs N-bit req and ptr; outputs one-hot grant and encoded index; purely combinational).
- The ALU itself is not instantiated here; the parent connects D1/D2/MS/ALU_out.

## Test plan
- Single request, requester 2: op=0, a=0x1234, b=0x0111. Required: req_ready[2] in cycle T, rsp_valid at T+2, rsp_data=0x1345, rsp_id=2, rsp_err=0.
- Wrap arithmetic:
  - sub 0x0000−0x0001 → rsp_data=0xFFFF
  - mul 0x0100·0x0100 → 0x0000
  - xor 0xAAAA^0xFFFF → 0x5555
- All 4 requesters valid from reset with rsp_ready=1. Required: grant order 0,1,2,3,0 and a response every 3 cycles with matching rsp_id.
- Reserved opcode: op=5, a=3, b=4. Required: rsp_data=0, rsp_err=1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid. Required: outputs stable, req_ready all 0, busy=1; accept occurs in the cycle after rsp_ready=1.
- Reset pulse during EXEC. Required: rsp_valid never asserts; D1=D2=0, MS=0, ptr=0 immediately. The next grant goes to the lowest-index valid requester.
